trigger_record_capture: RTL and testbench

- Sits directly downstream of the pre-trigger delay FIFO stage.
- Consumes the delayed packed sample pairs and that stage's ready flag, waits for an external trigger edge, and cuts fixed-length records out of the delayed stream.
- Because the upstream FIFO delays the stream, each record contains pre-trigger history.
- Emits records as a valid/first/last framed stream to the accumulation/readout logic, with record counting, holdoff and missed-trigger accounting.

---
 rtl/trigger_record_capture.sv | 179 +++++++++++++++++
 tb/tb_trigger_record_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/trigger_record_capture.sv
// Cuts fixed-length records out of the delayed sample stream on a trigger edge and frames them
// with valid/first/last, with per-run record counting, holdoff and missed-trigger accounting.
module trigger_record_capture #(
  parameter int unsigned BIT_WIDTH  = 14,
  parameter int unsigned RECORD_LEN = 1000,
  parameter int unsigned HOLDOFF    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*BIT_WIDTH-1:0] fifo_tc_datain,
  input  logic                   trigger_tc_ready,
  input  logic                   trigger_i,
  input  logic                   enable_i,
  input  logic [15:0]            record_num_i,
  output logic [2*BIT_WIDTH-1:0] rec_data_o,
  output logic                   rec_valid_o,
  output logic                   rec_first_o,
  output logic                   rec_last_o,
  output logic [15:0]            rec_index_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [7:0]             trig_missed_o
);

  localparam int unsigned DW = 2 * BIT_WIDTH;
  localparam int unsigned CW = $clog2(RECORD_LEN + 1);
  localparam int unsigned HW = $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] LastIdx  = CW'(RECORD_LEN - 1);
  localparam logic [HW-1:0] HoldLast = HW'(HOLDOFF - 1);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StWaitReady = 3'd1;
  localparam logic [2:0] StArmed     = 3'd2;
  localparam logic [2:0] StCapture   = 3'd3;
  localparam logic [2:0] StHoldoff   = 3'd4;
  localparam logic [2:0] StDone      = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          trig_q;
  logic [CW-1:0] sample_cnt_q, sample_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]   num_lat_q, num_lat_d;
  logic [15:0]   rec_count_q, rec_count_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic [15:0]   index_q, index_d;
  logic          done_q, done_d;
  logic [7:0]    missed_q, missed_d;
  logic          trig_edge;
  logic          missed_inc;

  assign trig_edge = trigger_i & ~trig_q;

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    num_lat_d    = num_lat_q;
    rec_count_d  = rec_count_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    first_d      = 1'b0;
    last_d       = 1'b0;
    index_d      = index_q;
    done_d       = 1'b0;
    missed_d     = missed_q;
    missed_inc   = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d     = StWaitReady;
          num_lat_d   = record_num_i;
          rec_count_d = 16'd0;
          missed_d    = 8'd0;
          index_d     = 16'd0;
        end
      end
      StWaitReady: begin
        if (trigger_tc_ready) state_d = StArmed;
        else if (!enable_i)   state_d = StIdle;
      end
      StArmed: begin
        if (!trigger_tc_ready) begin
          state_d = StWaitReady;
        end else if (trig_edge) begin
          // The pair present in the trigger cycle is pair 0 of the record.
          state_d      = StCapture;
          data_d       = fifo_tc_datain;
          valid_d      = 1'b1;
          first_d      = 1'b1;
          index_d      = rec_count_q;
          sample_cnt_d = CW'(1);
        end else if (!enable_i) begin
          state_d = StIdle;
        end
      end
      StCapture: begin
        missed_inc = trig_edge;
        if (!trigger_tc_ready) begin
          state_d = StWaitReady;
        end else begin
          data_d       = fifo_tc_datain;
          valid_d      = 1'b1;
          sample_cnt_d = sample_cnt_q + CW'(1);
          if (sample_cnt_q == LastIdx) begin
            last_d      = 1'b1;
            rec_count_d = rec_count_q + 16'd1;
            hold_cnt_d  = '0;
            if (num_lat_q != 16'd0 && rec_count_q + 16'd1 == num_lat_q) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else if (!enable_i) begin
              state_d = StIdle;
            end else begin
              state_d = StHoldoff;
            end
          end
        end
      end
      StHoldoff: begin
        missed_inc = trig_edge;
        if (!trigger_tc_ready) begin
          state_d = StWaitReady;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = enable_i ? StArmed : StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (missed_inc && missed_q != 8'hFF) missed_d = missed_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      trig_q       <= 1'b0;
      sample_cnt_q <= '0;
      hold_cnt_q   <= '0;
      num_lat_q    <= 16'd0;
      rec_count_q  <= 16'd0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      index_q      <= 16'd0;
      done_q       <= 1'b0;
      missed_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      trig_q       <= trigger_i;
      sample_cnt_q <= sample_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      num_lat_q    <= num_lat_d;
      rec_count_q  <= rec_count_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      first_q      <= first_d;
      last_q       <= last_d;
      index_q      <= index_d;
      done_q       <= done_d;
      missed_q     <= missed_d;
    end
  end

  assign rec_data_o    = data_q;
  assign rec_valid_o   = valid_q;
  assign rec_first_o   = first_q;
  assign rec_last_o    = last_q;
  assign rec_index_o   = index_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign trig_missed_o = missed_q;

endmodule

// File: tb/tb_trigger_record_capture.sv
// Directed run sequence with random sample data; expected records are derived from the recorded
// input history and the trigger cycle.
module tb_trigger_record_capture;

  localparam int BW = 14;
  localparam int DW = 2 * BW;
  localparam int L  = 1000;
  localparam int H  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] fifo_tc_datain = '0;
  logic          trigger_tc_ready = 1'b0;
  logic          trigger_i = 1'b0;
  logic          enable_i = 1'b0;
  logic [15:0]   record_num_i = 16'd0;
  logic [DW-1:0] rec_data_o;
  logic          rec_valid_o;
  logic          rec_first_o;
  logic          rec_last_o;
  logic [15:0]   rec_index_o;
  logic          busy_o;
  logic          done_o;
  logic [7:0]    trig_missed_o;

  trigger_record_capture #(
    .BIT_WIDTH (BW),
    .RECORD_LEN(L),
    .HOLDOFF   (H)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_tc_datain  (fifo_tc_datain),
    .trigger_tc_ready(trigger_tc_ready),
    .trigger_i       (trigger_i),
    .enable_i        (enable_i),
    .record_num_i    (record_num_i),
    .rec_data_o      (rec_data_o),
    .rec_valid_o     (rec_valid_o),
    .rec_first_o     (rec_first_o),
    .rec_last_o      (rec_last_o),
    .rec_index_o     (rec_index_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .trig_missed_o   (trig_missed_o)
  );

  initial forever #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            base = 0;
  bit            inc_mode = 1'b0;
  logic [DW-1:0] hist [0:16383];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock; inputs for the new cycle are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (inc_mode) hist[cyc] = DW'(cyc - base);
    else          hist[cyc] = DW'($urandom);
    fifo_tc_datain = hist[cyc];
  endtask

  // Raise a trigger edge in the current cycle t and watch `span` following cycles.
  // Pair k must appear at t+1+k; an abort at offset a keeps pairs 0..a-1 only.
  task automatic run_record(input int idx, input int span, input int off1, input int off2,
                            input int abort_at, input bit exp_done);
    int t;
    int npairs;
    t = cyc;
    npairs = (abort_at >= 0) ? abort_at : L;
    trigger_i = 1'b1;
    for (int d = 1; d <= span; d++) begin
      tick();
      trigger_i = (d == off1) || (d == off2);
      trigger_tc_ready = !(abort_at >= 0 && d >= abort_at);
      if (d <= npairs) begin
        check("valid", 64'(rec_valid_o), 64'(1));
        check("data", 64'(rec_data_o), 64'(hist[t+d-1]));
        check("first", 64'(rec_first_o), 64'(d == 1));
        check("last", 64'(rec_last_o), 64'(d == L));
        check("index", 64'(rec_index_o), 64'(idx));
        if (d < L) check("busy_cap", 64'(busy_o), 64'(1));
      end else begin
        check("valid_off", 64'(rec_valid_o), 64'(0));
        check("first_off", 64'(rec_first_o), 64'(0));
        check("last_off", 64'(rec_last_o), 64'(0));
        check("data_hold", 64'(rec_data_o), 64'(hist[t+npairs-1]));
      end
      check("done", 64'(done_o), 64'(exp_done && d == L));
    end
  endtask

  initial begin
    hist[0] = '0;
    // Reset values
    tick();
    tick();
    check("rst_valid", 64'(rec_valid_o), 64'(0));
    check("rst_data", 64'(rec_data_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_missed", 64'(trig_missed_o), 64'(0));
    check("rst_index", 64'(rec_index_o), 64'(0));

    // Two-record run on a counter stream, with ignored edges in capture and holdoff
    rst = 1'b0;
    enable_i = 1'b1;
    record_num_i = 16'd2;
    trigger_tc_ready = 1'b1;
    inc_mode = 1'b1;
    base = cyc + 2 - 100;
    tick();
    tick();
    check("armed_busy", 64'(busy_o), 64'(1));
    run_record(0, L + H, 10, L + 5, -1, 1'b0);
    check("missed_two", 64'(trig_missed_o), 64'(2));
    run_record(1, L + 1, -1, -1, -1, 1'b1);
    enable_i = 1'b0;
    tick();
    check("after_done_busy", 64'(busy_o), 64'(0));
    check("after_done_pulse", 64'(done_o), 64'(0));
    check("missed_kept", 64'(trig_missed_o), 64'(2));

    // Edges while not ready are neither captured nor counted
    inc_mode = 1'b0;
    enable_i = 1'b1;
    record_num_i = 16'd5;
    trigger_tc_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      trigger_i = (i % 2 == 0);
      tick();
      check("wr_valid", 64'(rec_valid_o), 64'(0));
      check("wr_busy", 64'(busy_o), 64'(1));
      check("wr_missed", 64'(trig_missed_o), 64'(0));
    end
    trigger_i = 1'b0;
    trigger_tc_ready = 1'b1;
    tick();
    // Ready drop at pair 500 aborts without last; the next record keeps index 0
    run_record(0, 505, -1, -1, 500, 1'b0);
    check("abort_busy", 64'(busy_o), 64'(1));
    trigger_tc_ready = 1'b1;
    tick();
    run_record(0, L + 2, -1, -1, -1, 1'b0);
    enable_i = 1'b0;
    repeat (H + 2) tick();
    check("holdoff_to_idle", 64'(busy_o), 64'(0));

    // Continuous mode: three records, enable dropped together with the third trigger
    enable_i = 1'b1;
    record_num_i = 16'd0;
    tick();
    tick();
    run_record(0, L + H, -1, -1, -1, 1'b0);
    run_record(1, L + H, -1, -1, -1, 1'b0);
    enable_i = 1'b0;
    run_record(2, L + 1, -1, -1, -1, 1'b0);
    check("cont_idle", 64'(busy_o), 64'(0));
    check("cont_missed", 64'(trig_missed_o), 64'(0));

    // Asynchronous reset mid-capture
    enable_i = 1'b1;
    record_num_i = 16'd3;
    tick();
    tick();
    run_record(0, 20, 5, -1, -1, 1'b0);
    check("pre_rst_missed", 64'(trig_missed_o), 64'(1));
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(rec_valid_o), 64'(0));
    check("arst_data", 64'(rec_data_o), 64'(0));
    check("arst_first", 64'(rec_first_o), 64'(0));
    check("arst_busy", 64'(busy_o), 64'(0));
    check("arst_missed", 64'(trig_missed_o), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    run_record(0, L + 1, -1, -1, -1, 1'b0);
    check("post_rst_missed", 64'(trig_missed_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
